sha2_msg_sched: RTL and testbench

SHA-256 message-schedule generator and block reader. It consumes one assembled 512-bit message block from the input datapath, which is held as eight 64-bit packets with packet 0 in bits [63:0], through a valid/ready handshake. It then streams the 64 schedule words W0..W63 to the compression round engine, one 32-bit word per accepted handshake. It is the read side of the packet register file: the input datapath writes packets in, and this block unpacks and expands them.

---
 rtl/sha2_pkg.sv | 28 ++
 rtl/sha2_sigma.sv | 16 +
 rtl/sha2_msg_sched.sv | 99 +++++++++
 tb/tb_sha2_msg_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-256 constants, state encoding and the rotate helper used by the
// message-schedule datapath.
package sha2_pkg;

    localparam int BLK_W  = 512;
    localparam int WORD_W = 32;
    localparam int PKT_W  = 64;
    localparam int ROUNDS = 64;
    localparam int NPKT   = BLK_W / PKT_W;
    localparam int WIN_N  = 16;

    localparam int S0_ROT1 = 7;
    localparam int S0_ROT2 = 18;
    localparam int S0_SHR  = 3;
    localparam int S1_ROT1 = 17;
    localparam int S1_ROT2 = 19;
    localparam int S1_SHR  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/sha2_sigma.sv
// Combinational SHA-256 small sigma: ROTR(R1) ^ ROTR(R2) ^ SHR(SH) of one word.
// The rotate/shift amounts select sigma0 or sigma1.
module sha2_sigma
    import sha2_pkg::*;
#(
    parameter int R1 = S0_ROT1,
    parameter int R2 = S0_ROT2,
    parameter int SH = S0_SHR
) (
    input  logic [WORD_W-1:0] x_i,
    output logic [WORD_W-1:0] y_o
);

    assign y_o = rotr(x_i, R1) ^ rotr(x_i, R2) ^ (x_i >> SH);

endmodule

// File: rtl/sha2_msg_sched.sv
// SHA-256 message-schedule generator: accepts one 512-bit block and streams
// W0..W63 through a 16-word shift window, one word per w_vld/w_rdy handshake.
module sha2_msg_sched #(
    parameter int ROUNDS = sha2_pkg::ROUNDS,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        clr,
    input  logic                        blk_vld,
    input  logic [sha2_pkg::BLK_W-1:0]  blk,
    output logic                        blk_rdy,
    output logic                        w_vld,
    output logic [sha2_pkg::WORD_W-1:0] w,
    output logic [IDX_W-1:0]            w_idx,
    output logic                        w_last,
    input  logic                        w_rdy
);

    import sha2_pkg::*;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] win_q [WIN_N];
    logic [WORD_W-1:0] win_d [WIN_N];
    logic [IDX_W-1:0]  t_q, t_d;

    logic [WORD_W-1:0] sig0, sig1, w_new;
    logic              last_word;

    sha2_sigma #(.R1(S0_ROT1), .R2(S0_ROT2), .SH(S0_SHR)) u_sigma0 (
        .x_i (win_q[1]),
        .y_o (sig0)
    );

    sha2_sigma #(.R1(S1_ROT1), .R2(S1_ROT2), .SH(S1_SHR)) u_sigma1 (
        .x_i (win_q[14]),
        .y_o (sig1)
    );

    // The word entering the window is W[t+16], so it is ready a full cycle early.
    assign w_new     = sig1 + win_q[9] + sig0 + win_q[0];
    assign last_word = (t_q == IDX_W'(ROUNDS - 1));

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (blk_vld) begin
                    state_d = RUN;
                    t_d     = '0;
                    // Big-endian within each packet: upper half is the earlier word.
                    for (int k = 0; k < NPKT; k++) begin
                        win_d[2*k]   = blk[PKT_W*k + WORD_W +: WORD_W];
                        win_d[2*k+1] = blk[PKT_W*k +: WORD_W];
                    end
                end
            end
            RUN: begin
                if (w_rdy) begin
                    if (last_word) begin
                        state_d = IDLE;
                        t_d     = '0;
                        for (int i = 0; i < WIN_N; i++) win_d[i] = '0;
                    end else begin
                        for (int i = 0; i < WIN_N - 1; i++) win_d[i] = win_q[i+1];
                        win_d[WIN_N-1] = w_new;
                        t_d            = t_q + 1'b1;
                    end
                end
            end
        endcase
        if (clr) begin
            state_d = IDLE;
            t_d     = '0;
            for (int i = 0; i < WIN_N; i++) win_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            t_q     <= '0;
            for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            for (int i = 0; i < WIN_N; i++) win_q[i] <= win_d[i];
        end
    end

    assign blk_rdy = (state_q == IDLE);
    assign w_vld   = (state_q == RUN);
    assign w       = w_vld ? win_q[0] : '0;
    assign w_idx   = t_q;
    assign w_last  = w_vld && last_word;

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Bench for sha2_msg_sched: a transaction-level SHA-256 schedule model checked
// against the DUT every cycle, plus directed scenarios and literal anchors.
module tb_sha2_msg_sched;

    localparam int ROUNDS = 64;
    localparam int IDX_W  = 6;
    localparam logic [511:0] ABC = {64'h0000_0000_0000_0018, 384'h0, 64'h6162_6380_0000_0000};
    localparam logic [511:0] ONES = {512{1'b1}};

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             clr = 1'b0;
    logic             blk_vld = 1'b0;
    logic [511:0]     blk = '0;
    logic             w_rdy = 1'b0;
    logic             blk_rdy;
    logic             w_vld;
    logic [31:0]      w;
    logic [IDX_W-1:0] w_idx;
    logic             w_last;

    always #5 clk = ~clk;

    sha2_msg_sched #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (clr),
        .blk_vld (blk_vld),
        .blk     (blk),
        .blk_rdy (blk_rdy),
        .w_vld   (w_vld),
        .w       (w),
        .w_idx   (w_idx),
        .w_last  (w_last),
        .w_rdy   (w_rdy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
    endfunction

    // Textbook SHA-256 schedule: W[t] for the whole block at once.
    function automatic logic [63:0][31:0] expand(input logic [511:0] b);
        logic [63:0][31:0] ws;
        for (int t = 0; t < 16; t++)
            ws[t] = b[64*(t/2) + ((t % 2 == 0) ? 32 : 0) +: 32];
        for (int t = 16; t < 64; t++)
            ws[t] = ss1(ws[t-2]) + ws[t-7] + ss0(ws[t-15]) + ws[t-16];
        return ws;
    endfunction

    // Transaction model: busy flag, word index, and the precomputed schedule.
    bit                mdl_busy = 1'b0;
    int                mdl_t = 0;
    logic [63:0][31:0] mdl_w = '0;
    logic [31:0]       cap [64];
    int                cyc = 0;
    int                acc_cyc = 0;
    int                w63_cyc = 0;
    bit                stall_chk = 1'b0;
    logic [31:0]       sv_w = '0;
    logic [IDX_W-1:0]  sv_idx = '0;

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_b);
            if (!rst_b) begin
                mdl_busy  = 1'b0;
                mdl_t     = 0;
                stall_chk = 1'b0;
            end else begin
                cyc++;
                stall_chk = w_vld && !w_rdy && !clr;
                sv_w      = w;
                sv_idx    = w_idx;
                if (clr) begin
                    mdl_busy = 1'b0;
                    mdl_t    = 0;
                end else if (!mdl_busy) begin
                    if (blk_vld) begin
                        mdl_busy = 1'b1;
                        mdl_t    = 0;
                        mdl_w    = expand(blk);
                        acc_cyc  = cyc;
                    end
                end else if (w_rdy) begin
                    cap[mdl_t] = w;
                    if (mdl_t == ROUNDS - 1) begin
                        mdl_busy = 1'b0;
                        mdl_t    = 0;
                        w63_cyc  = cyc;
                    end else begin
                        mdl_t++;
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_b) begin
                chk("blk_rdy", 32'(blk_rdy), 32'(!mdl_busy));
                chk("w_vld", 32'(w_vld), 32'(mdl_busy));
                chk("w_idx", 32'(w_idx), mdl_busy ? 32'(mdl_t) : 32'd0);
                chk("w", w, mdl_busy ? mdl_w[mdl_t] : 32'd0);
                chk("w_last", 32'(w_last), 32'(mdl_busy && mdl_t == ROUNDS - 1));
                if (stall_chk) begin
                    chk("stall_w", w, sv_w);
                    chk("stall_idx", 32'(w_idx), 32'(sv_idx));
                end
            end
        end
    end

    task automatic run_block(input logic [511:0] b, input bit rnd,
                             output logic [31:0] w0, output logic [IDX_W-1:0] idx0);
        bit done;
        @(negedge clk);
        blk     = b;
        blk_vld = 1'b1;
        w_rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        w0      = w;
        idx0    = w_idx;
        blk_vld = 1'b0;
        done    = blk_rdy;
        for (int i = 0; i < 2000 && !done; i++) begin
            w_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            done = blk_rdy;
        end
        if (!done) timeout("block_complete");
        w_rdy = 1'b0;
    endtask

    task automatic wait_idx(input int target, input string name);
        bit hit;
        hit = (w_vld && 32'(w_idx) == target);
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            hit = (w_vld && 32'(w_idx) == target);
        end
        if (!hit) timeout(name);
    endtask

    task automatic wait_rdy_high(input string name);
        bit hit;
        hit = blk_rdy;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            hit = blk_rdy;
        end
        if (!hit) timeout(name);
    endtask

    logic [63:0][31:0] abc_w;
    logic [31:0]       w0;
    logic [IDX_W-1:0]  idx0;
    logic [511:0]      rb;

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("rst_blk_rdy", 32'(blk_rdy), 32'd1);
        chk("rst_w_vld", 32'(w_vld), 32'd0);
        chk("rst_w", w, 32'd0);
        chk("rst_w_idx", 32'(w_idx), 32'd0);
        chk("rst_w_last", 32'(w_last), 32'd0);
        rst_b = 1'b1;

        abc_w = expand(ABC);
        chk("model_W0", abc_w[0], 32'h6162_6380);
        chk("model_W15", abc_w[15], 32'h0000_0018);
        chk("model_W16", abc_w[16], 32'h6162_6380);
        chk("model_W17", abc_w[17], 32'h000F_0000);
        chk("model_W18", abc_w[18], 32'h7DA8_6405);

        // abc block, no backpressure
        run_block(ABC, 1'b0, w0, idx0);
        chk("abc_first_w", w0, 32'h6162_6380);
        chk("abc_first_idx", 32'(idx0), 32'd0);
        chk("abc_W1", cap[1], 32'h0);
        chk("abc_W14", cap[14], 32'h0);
        chk("abc_W15", cap[15], 32'h0000_0018);
        chk("abc_W16", cap[16], 32'h6162_6380);
        chk("abc_W17", cap[17], 32'h000F_0000);
        chk("abc_W18", cap[18], 32'h7DA8_6405);
        chk("abc_W63", cap[63], abc_w[63]);
        chk("abc_span", 32'(w63_cyc - acc_cyc), 32'd64);
        chk("abc_rdy_after", 32'(blk_rdy), 32'd1);

        // same block under random backpressure
        run_block(ABC, 1'b1, w0, idx0);
        chk("bp_W17", cap[17], 32'h000F_0000);
        chk("bp_W18", cap[18], 32'h7DA8_6405);
        chk("bp_W63", cap[63], abc_w[63]);

        // back-to-back with blk_vld held; the second blk shows up during RUN
        @(negedge clk);
        blk     = ABC;
        blk_vld = 1'b1;
        w_rdy   = 1'b1;
        @(negedge clk);
        chk("b2b_accept1", 32'(blk_rdy), 32'd0);
        blk = ONES;
        wait_rdy_high("b2b_idle");
        @(negedge clk);
        chk("b2b_accept2", 32'(blk_rdy), 32'd0);
        chk("b2b_gap", 32'(acc_cyc - w63_cyc), 32'd1);
        chk("b2b_first_W18", cap[18], 32'h7DA8_6405);
        chk("b2b_second_W0", w, 32'hFFFF_FFFF);
        chk("b2b_second_idx", 32'(w_idx), 32'd0);
        blk_vld = 1'b0;
        wait_rdy_high("b2b_done");
        w_rdy = 1'b0;

        // abort at t=20
        @(negedge clk);
        blk     = ABC;
        blk_vld = 1'b1;
        w_rdy   = 1'b1;
        @(negedge clk);
        blk_vld = 1'b0;
        wait_idx(20, "abort_reach20");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort_w_vld", 32'(w_vld), 32'd0);
        chk("abort_blk_rdy", 32'(blk_rdy), 32'd1);
        chk("abort_w_idx", 32'(w_idx), 32'd0);
        run_block(ONES, 1'b0, w0, idx0);
        chk("abort_reoffer_W0", w0, 32'hFFFF_FFFF);
        chk("abort_reoffer_idx", 32'(idx0), 32'd0);

        // asynchronous reset while stalled at t=40
        @(negedge clk);
        blk     = ABC;
        blk_vld = 1'b1;
        w_rdy   = 1'b1;
        @(negedge clk);
        blk_vld = 1'b0;
        wait_idx(40, "areset_reach40");
        w_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("areset_pre_vld", 32'(w_vld), 32'd1);
        chk("areset_pre_idx", 32'(w_idx), 32'd40);
        #2 rst_b = 1'b0;
        #1;
        chk("areset_blk_rdy", 32'(blk_rdy), 32'd1);
        chk("areset_w_vld", 32'(w_vld), 32'd0);
        chk("areset_w", w, 32'd0);
        chk("areset_w_idx", 32'(w_idx), 32'd0);
        chk("areset_w_last", 32'(w_last), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        run_block(ABC, 1'b0, w0, idx0);
        chk("recover_W0", w0, 32'h6162_6380);
        chk("recover_W18", cap[18], 32'h7DA8_6405);
        chk("recover_W63", cap[63], abc_w[63]);

        // random blocks with random backpressure
        for (int n = 0; n < 3; n++) begin
            for (int j = 0; j < 16; j++) rb[32*j +: 32] = $urandom;
            run_block(rb, 1'b1, w0, idx0);
            chk("rand_W0", w0, rb[63:32]);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
